sync_fifo_buf: RTL

//  Single-clock, parametrised FIFO buffer for the UART-to-DDR data path. Successor to the

---
 rtl/sync_fifo_buf.sv | 95 +++++++++
 1 files changed

// File: rtl/sync_fifo_buf.sv
// Single-clock FIFO with registered read data, occupancy counter and threshold flags.
// Optional sticky overflow/underflow error flags are enabled by defining FIFO_ERR_FLAGS_EN.
module sync_fifo_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int PTR_WIDTH  = 4,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
`endif
);

    localparam logic [PTR_WIDTH:0] CNT_FULL = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] CNT_AF   = (PTR_WIDTH+1)'(AF_LEVEL);
    localparam logic [PTR_WIDTH:0] CNT_AE   = (PTR_WIDTH+1)'(AE_LEVEL);
    localparam logic [PTR_WIDTH:0] ONE      = (PTR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH:0]    wptr, rptr;
    logic                  wr_ok, rd_ok;

    // Accept decisions use pre-edge flags: a read never frees room for a same-cycle write.
    assign wr_ok = w_en & ~full;
    assign rd_ok = r_en & ~empty;

    assign full         = (count == CNT_FULL);
    assign empty        = (count == '0);
    assign almost_full  = (count >= CNT_AF);
    assign almost_empty = (count <= CNT_AE);

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wptr[PTR_WIDTH-1:0]] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (wr_ok)
                wptr <= wptr + ONE;
            if (rd_ok) begin
                rptr     <= rptr + ONE;
                data_out <= mem[rptr[PTR_WIDTH-1:0]];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky error flags; clear wins over a same-cycle set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (err_clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en & full)
                overflow <= 1'b1;
            if (r_en & empty)
                underflow <= 1'b1;
        end
    end
`endif

endmodule
